indirect_target_predictor: RTL
==============================

INDIRECT_TARGET_PREDICTOR -- requirements
Module: indirect_target_predictor

Interface
REQ-001 Parameters SHALL be: WAYS, default 2, associativity (1..8); SETS_LOG2, default 6, log2 of set count; TAG_W, default 10, tag width; PATH_DEPTH, default 6, number of 32-bit path-history entries; STAGES, default 3, lookup-to-update pipeline depth (>=2).
REQ-002 The block SHALL use one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 Lookup ports SHALL be: pc_in  in  32  branch PC; lookup_en  in  1  lookup request; stall  in  1  pipeline freeze.
REQ-004 Prediction outputs SHALL be: pred_target_o  out  32  predicted target; pred_hit_o  out  1  tagged hit; pred_valid_o  out  1  prediction strobe.
REQ-005 History ports SHALL be: spec_push  in  1  speculative history shift; spec_addr  in  32  speculative branch address; commit_push  in  1  committed history shift; commit_addr  in  32  resolved branch address; recover  in  1  mispredict restore.
REQ-006 Update ports SHALL be: upd_en  in  1  resolve update for oldest pipeline entry; upd_target  in  32  resolved target.

Function
REQ-007 Storage: 2^SETS_LOG2 sets x WAYS ways; each entry holds valid, TAG_W tag, 32-bit target, 2-bit confidence; one round-robin victim pointer per set (ceil(log2 WAYS) bits; absent if WAYS=1).
REQ-008 Path fold P (32 bits) = XOR of all PATH_DEPTH speculative history entries, combinational.
REQ-009 Set index = P[SETS_LOG2+2:3] XOR pc_in[SETS_LOG2+2:3]; tag = P[TAG_W+SETS_LOG2+2:SETS_LOG2+3] XOR pc_in[TAG_W+SETS_LOG2+2:SETS_LOG2+3]; bits above 31 read as 0.
REQ-010 Lookup latency 1 cycle: lookup_en=1 with stall=0 at edge N produces pred_valid_o=1 after edge N for exactly one cycle; otherwise pred_valid_o=0.
REQ-011 Hit = valid AND tag match; multiple hits resolve to lowest-numbered way; on hit pred_target_o = that way's target, pred_hit_o=1; on miss pred_target_o=0, pred_hit_o=0.
REQ-012 Lookup and update to the same entry in the same cycle: lookup returns pre-update contents.
REQ-013 Each lookup pushes {valid=1, set, tag, hit, hit_way, predicted target} into a STAGES-deep shift register; cycles with lookup_en=0 and stall=0 push an invalid slot; stall=1 freezes the shift register and suppresses lookup.
REQ-014 upd_en acts on the oldest slot in the same cycle; upd_en with oldest slot invalid SHALL be ignored; stall does not block updates.
REQ-015 Update on recorded hit: if upd_target equals the entry's stored target, confidence saturating-increments (max 3); otherwise confidence decrements, and if confidence was 0 the target is replaced by upd_target with confidence 1.
REQ-016 Update on recorded miss: allocate lowest-numbered invalid way of the set, else the way at the victim pointer; write valid=1, tag, upd_target, confidence 1; victim pointer advances modulo WAYS only when a valid way was evicted.
REQ-017 Speculative history: spec_push=1 with stall=0 and recover=0 shifts spec_addr into entry 0, discarding entry PATH_DEPTH-1.
REQ-018 Committed history: commit_push=1 shifts commit_addr in identically, independent of stall and recover.
REQ-019 recover=1 overrides spec_push: speculative history loads the committed history's next value (including a same-cycle commit_push).
REQ-020 Arithmetic: confidence saturates at 0 and 3; set index and victim pointer wrap modulo their ranges, no overflow flags.

Reset
REQ-021 rst=1 at an edge SHALL clear all valid bits, confidences, victim pointers, both histories and all pipeline slots; pred_target_o=0, pred_hit_o=0, pred_valid_o=0 after that edge.
REQ-022 rst overrides every other input, including mid-lookup and mid-update; targets and tags need not be cleared (invalid entries unobservable).
REQ-023 The first lookup after rst deasserts SHALL be a miss with P=0.

Verification
REQ-024 Cold miss/allocate: reset; lookup pc_in=0x0000_1040; after 3 cycles upd_en, upd_target=0x0000_8000; relookup 0x1040 -> pred_hit_o=1, pred_target_o=0x8000.
REQ-025 Confidence/replace: entry conf=1 target 0x8000; two updates with upd_target=0x9000 -> first conf 0 target unchanged, second target 0x9000 conf 1.
REQ-026 Associativity: three PCs mapping to set 4 with distinct tags, WAYS=2 -> third allocation evicts way 0, pointer becomes 1; first PC now misses, second still hits.
REQ-027 Recovery: commit 0x100,0x200; speculatively push 0xAAA0,0xBBB0; assert recover -> P equals 0x100^0x200 and lookup indexes match committed-only state.
REQ-028 Stall: lookup_en=1 with stall=1 for 4 cycles -> pred_valid_o stays 0, pipeline and spec history unchanged; upd_en during stall still updates oldest slot.
REQ-029 Reset mid-operation: rst during pending pipeline slots -> subsequent upd_en ignored, all lookups miss.

Source files
------------

// File: rtl/indirect_target_predictor.sv
// Set-associative indirect branch target predictor indexed by PC hashed with a
// folded path history; lookups are tracked in a fixed-depth pipeline for later update.
module indirect_target_predictor #(
  parameter int WAYS       = 2,
  parameter int SETS_LOG2  = 6,
  parameter int TAG_W      = 10,
  parameter int PATH_DEPTH = 6,
  parameter int STAGES     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        lookup_en,
  input  logic        stall,
  output logic [31:0] pred_target_o,
  output logic        pred_hit_o,
  output logic        pred_valid_o,
  input  logic        spec_push,
  input  logic [31:0] spec_addr,
  input  logic        commit_push,
  input  logic [31:0] commit_addr,
  input  logic        recover,
  input  logic        upd_en,
  input  logic [31:0] upd_target
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic                 valid;
    logic [SETS_LOG2-1:0] set;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic [WAY_W-1:0]     way;
    logic [31:0]          target;
  } slot_t;

  logic                 ent_valid  [SETS][WAYS];
  logic [1:0]           ent_conf   [SETS][WAYS];
  logic [TAG_W-1:0]     ent_tag    [SETS][WAYS];
  logic [31:0]          ent_target [SETS][WAYS];
  logic [WAY_W-1:0]     victim     [SETS];

  logic [31:0] spec_hist   [PATH_DEPTH];
  logic [31:0] commit_hist [PATH_DEPTH];
  logic [31:0] commit_next [PATH_DEPTH];
  slot_t       pipe        [STAGES];

  logic [31:0]          path_fold;
  logic [31:0]          hashed;
  logic [SETS_LOG2-1:0] lk_set;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;
  logic [WAY_W-1:0]     lk_way;
  logic [31:0]          lk_target;

  always_comb begin
    path_fold = '0;
    for (int i = 0; i < PATH_DEPTH; i++) path_fold ^= spec_hist[i];
  end

  // Zero-extend to 64 bits so tag bits beyond bit 31 read as zero.
  assign hashed = path_fold ^ pc_in;
  assign lk_set = SETS_LOG2'({32'b0, hashed} >> 3);
  assign lk_tag = TAG_W'({32'b0, hashed} >> (SETS_LOG2 + 3));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lk_hit    = 1'b0;
    lk_way    = '0;
    lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && ent_valid[lk_set][w] && ent_tag[lk_set][w] == lk_tag) begin
        lk_hit    = 1'b1;
        lk_way    = WAY_W'(w);
        lk_target = ent_target[lk_set][w];
      end
    end
  end

  // Update decode for the oldest pipeline slot.
  slot_t            oldest;
  logic             upd_fire;
  logic [WAY_W-1:0] wr_way;
  logic [1:0]       wr_conf;
  logic             wr_tgt_en;
  logic             wr_alloc;
  logic             victim_adv;
  logic             free_found;
  logic [31:0]      cur_tgt;
  logic [1:0]       cur_conf;

  assign oldest   = pipe[STAGES-1];
  assign upd_fire = upd_en && oldest.valid;
  assign cur_tgt  = ent_target[oldest.set][oldest.way];
  assign cur_conf = ent_conf[oldest.set][oldest.way];

  always_comb begin
    wr_way     = oldest.way;
    wr_conf    = cur_conf;
    wr_tgt_en  = 1'b0;
    wr_alloc   = 1'b0;
    victim_adv = 1'b0;
    free_found = 1'b0;
    if (oldest.hit) begin
      if (upd_target == cur_tgt) begin
        wr_conf = (cur_conf == 2'd3) ? 2'd3 : cur_conf + 2'd1;
      end else if (cur_conf == 2'd0) begin
        wr_tgt_en = 1'b1;
        wr_conf   = 2'd1;
      end else begin
        wr_conf = cur_conf - 2'd1;
      end
    end else begin
      wr_way = victim[oldest.set];
      for (int w = 0; w < WAYS; w++) begin
        if (!free_found && !ent_valid[oldest.set][w]) begin
          free_found = 1'b1;
          wr_way     = WAY_W'(w);
        end
      end
      victim_adv = !free_found;
      wr_alloc   = 1'b1;
      wr_tgt_en  = 1'b1;
      wr_conf    = 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < PATH_DEPTH; i++) commit_next[i] = commit_hist[i];
    if (commit_push) begin
      commit_next[0] = commit_addr;
      for (int i = 1; i < PATH_DEPTH; i++) commit_next[i] = commit_hist[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        victim[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          ent_valid[s][w] <= 1'b0;
          ent_conf[s][w]  <= 2'd0;
        end
      end
      for (int i = 0; i < PATH_DEPTH; i++) begin
        spec_hist[i]   <= '0;
        commit_hist[i] <= '0;
      end
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
      pred_valid_o  <= 1'b0;
      pred_hit_o    <= 1'b0;
      pred_target_o <= '0;
    end else begin
      pred_valid_o  <= lookup_en && !stall;
      pred_hit_o    <= lookup_en && !stall && lk_hit;
      pred_target_o <= (lookup_en && !stall) ? lk_target : '0;

      if (!stall) begin
        for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        pipe[0] <= lookup_en ? slot_t'{1'b1, lk_set, lk_tag, lk_hit, lk_way, lk_target}
                             : '0;
      end

      if (upd_fire) begin
        ent_conf[oldest.set][wr_way] <= wr_conf;
        if (wr_alloc) ent_valid[oldest.set][wr_way] <= 1'b1;
        if (victim_adv)
          victim[oldest.set] <= (victim[oldest.set] == WAY_W'(WAYS - 1)) ? '0
                                : victim[oldest.set] + 1'b1;
      end

      for (int i = 0; i < PATH_DEPTH; i++) commit_hist[i] <= commit_next[i];
      if (recover) begin
        for (int i = 0; i < PATH_DEPTH; i++) spec_hist[i] <= commit_next[i];
      end else if (spec_push && !stall) begin
        spec_hist[0] <= spec_addr;
        for (int i = 1; i < PATH_DEPTH; i++) spec_hist[i] <= spec_hist[i-1];
      end
    end
  end

  // NOTE: tag/target arrays are deliberately not reset; valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (!rst && upd_fire) begin
      if (wr_tgt_en) ent_target[oldest.set][wr_way] <= upd_target;
      if (wr_alloc)  ent_tag[oldest.set][wr_way]    <= oldest.tag;
    end
  end

endmodule
